// File: rtl/network_perf_monitor.sv
// Multi-channel windowed throughput/latency monitor: per-channel armed windows accumulate
// saturating byte/event counts, capture time-to-threshold, and snapshot at window end.
module network_perf_monitor #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 64,
  parameter int unsigned LEN_W  = 16,
  parameter int unsigned SEL_W  = 2
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [31:0]             cfg_window,
  input  logic [CNT_W-1:0]        cfg_threshold,
  input  logic                    cfg_periodic,
  input  logic                    clear,
  input  logic [NUM_CH-1:0]       start_evt,
  input  logic [NUM_CH-1:0]       byte_evt,
  input  logic [NUM_CH*LEN_W-1:0] byte_len,
  input  logic [SEL_W-1:0]        rd_sel,
  output logic [CNT_W-1:0]        rd_bytes,
  output logic [CNT_W-1:0]        rd_events,
  output logic [CNT_W-1:0]        rd_thresh_cycle,
  output logic                    rd_thresh_hit,
  output logic                    rd_snap_valid,
  output logic [2*NUM_CH-1:0]     ch_state,
  output logic [NUM_CH-1:0]       win_done
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHold = 2'd2
  } state_e;

  // Sum wide enough to hold either operand plus a carry, for saturation detection.
  localparam int unsigned SUM_W = ((CNT_W > LEN_W) ? CNT_W : LEN_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q       [NUM_CH];
  logic [31:0]      win_q         [NUM_CH];
  logic [31:0]      cyc_q         [NUM_CH];
  logic [CNT_W-1:0] bytes_q       [NUM_CH];
  logic [CNT_W-1:0] events_q      [NUM_CH];
  logic [CNT_W-1:0] tcyc_q        [NUM_CH];
  logic             tflag_q       [NUM_CH];
  logic [CNT_W-1:0] snap_bytes_q  [NUM_CH];
  logic [CNT_W-1:0] snap_events_q [NUM_CH];
  logic [CNT_W-1:0] snap_tcyc_q   [NUM_CH];
  logic             snap_thit_q   [NUM_CH];
  logic             snap_valid_q  [NUM_CH];

  logic [CNT_W-1:0] bytes_nx  [NUM_CH];
  logic [CNT_W-1:0] events_nx [NUM_CH];
  logic [CNT_W-1:0] tcyc_nx   [NUM_CH];
  logic             tflag_nx  [NUM_CH];
  logic             last      [NUM_CH];

  always_comb begin
    logic [SUM_W-1:0] sum;
    logic             hit;
    ch_state = '0;
    win_done = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum          = SUM_W'(bytes_q[i]) + SUM_W'(byte_len[i*LEN_W +: LEN_W]);
      bytes_nx[i]  = bytes_q[i];
      events_nx[i] = events_q[i];
      if (byte_evt[i]) begin
        bytes_nx[i]  = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
        events_nx[i] = (events_q[i] == CNT_MAX) ? CNT_MAX : events_q[i] + CNT_W'(1);
      end
      hit          = (cfg_threshold != '0) && !tflag_q[i] && (bytes_nx[i] >= cfg_threshold);
      tflag_nx[i]  = tflag_q[i] | hit;
      tcyc_nx[i]   = hit ? CNT_W'(cyc_q[i]) : tcyc_q[i];
      last[i]      = (state_q[i] == StRun) && (cyc_q[i] == win_q[i] - 32'd1);
      win_done[i]  = last[i] && !clear;
      ch_state[2*i +: 2] = state_q[i];
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]       <= StIdle;
        win_q[i]         <= '0;
        cyc_q[i]         <= '0;
        bytes_q[i]       <= '0;
        events_q[i]      <= '0;
        tcyc_q[i]        <= '0;
        tflag_q[i]       <= 1'b0;
        snap_bytes_q[i]  <= '0;
        snap_events_q[i] <= '0;
        snap_tcyc_q[i]   <= '0;
        snap_thit_q[i]   <= 1'b0;
        snap_valid_q[i]  <= 1'b0;
      end
    end else if (clear) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]       <= StIdle;
        cyc_q[i]         <= '0;
        bytes_q[i]       <= '0;
        events_q[i]      <= '0;
        tcyc_q[i]        <= '0;
        tflag_q[i]       <= 1'b0;
        snap_bytes_q[i]  <= '0;
        snap_events_q[i] <= '0;
        snap_tcyc_q[i]   <= '0;
        snap_thit_q[i]   <= 1'b0;
        snap_valid_q[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        unique case (state_q[i])
          StIdle, StHold: begin
            if (start_evt[i] && (cfg_window != 32'd0)) begin
              state_q[i]  <= StRun;
              win_q[i]    <= cfg_window;
              cyc_q[i]    <= '0;
              bytes_q[i]  <= '0;
              events_q[i] <= '0;
              tcyc_q[i]   <= '0;
              tflag_q[i]  <= 1'b0;
            end
          end
          StRun: begin
            if (last[i]) begin
              snap_bytes_q[i]  <= bytes_nx[i];
              snap_events_q[i] <= events_nx[i];
              snap_tcyc_q[i]   <= tcyc_nx[i];
              snap_thit_q[i]   <= tflag_nx[i];
              snap_valid_q[i]  <= 1'b1;
              // Counters restart immediately so a periodic window has no gap cycle.
              cyc_q[i]         <= '0;
              bytes_q[i]       <= '0;
              events_q[i]      <= '0;
              tcyc_q[i]        <= '0;
              tflag_q[i]       <= 1'b0;
              state_q[i]       <= cfg_periodic ? StRun : StHold;
            end else begin
              cyc_q[i]    <= cyc_q[i] + 32'd1;
              bytes_q[i]  <= bytes_nx[i];
              events_q[i] <= events_nx[i];
              tcyc_q[i]   <= tcyc_nx[i];
              tflag_q[i]  <= tflag_nx[i];
            end
          end
          default: state_q[i] <= StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rd_bytes        <= '0;
      rd_events       <= '0;
      rd_thresh_cycle <= '0;
      rd_thresh_hit   <= 1'b0;
      rd_snap_valid   <= 1'b0;
    end else if (32'(rd_sel) < NUM_CH) begin
      rd_bytes        <= snap_bytes_q[rd_sel];
      rd_events       <= snap_events_q[rd_sel];
      rd_thresh_cycle <= snap_tcyc_q[rd_sel];
      rd_thresh_hit   <= snap_thit_q[rd_sel];
      rd_snap_valid   <= snap_valid_q[rd_sel];
    end else begin
      rd_bytes        <= '0;
      rd_events       <= '0;
      rd_thresh_cycle <= '0;
      rd_thresh_hit   <= 1'b0;
      rd_snap_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_network_perf_monitor.sv
// Bench for network_perf_monitor: a default instance plus a narrow-counter (CNT_W=8, NUM_CH=3)
// instance for saturation and out-of-range readout.
module tb_network_perf_monitor;

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] cfg_window;
  logic [63:0] cfg_threshold;
  logic        cfg_periodic;
  logic        clear;
  logic [3:0]  start_evt, byte_evt;
  logic [63:0] byte_len;
  logic [1:0]  rd_sel;
  logic [63:0] rd_bytes, rd_events, rd_thresh_cycle;
  logic        rd_thresh_hit, rd_snap_valid;
  logic [7:0]  ch_state;
  logic [3:0]  win_done;

  logic [7:0]  s_threshold;
  logic [2:0]  s_start, s_bevt;
  logic [47:0] s_len;
  logic [1:0]  s_rd_sel;
  logic [7:0]  s_rd_bytes, s_rd_events, s_rd_tcyc;
  logic        s_rd_thit, s_rd_valid;
  logic [5:0]  s_ch_state;
  logic [2:0]  s_win_done;

  network_perf_monitor #(.NUM_CH(4), .CNT_W(64), .LEN_W(16), .SEL_W(2)) u_dut (
    .aclk(aclk), .areset(areset), .cfg_window(cfg_window), .cfg_threshold(cfg_threshold),
    .cfg_periodic(cfg_periodic), .clear(clear), .start_evt(start_evt), .byte_evt(byte_evt),
    .byte_len(byte_len), .rd_sel(rd_sel), .rd_bytes(rd_bytes), .rd_events(rd_events),
    .rd_thresh_cycle(rd_thresh_cycle), .rd_thresh_hit(rd_thresh_hit),
    .rd_snap_valid(rd_snap_valid), .ch_state(ch_state), .win_done(win_done)
  );

  network_perf_monitor #(.NUM_CH(3), .CNT_W(8), .LEN_W(16), .SEL_W(2)) u_sat (
    .aclk(aclk), .areset(areset), .cfg_window(cfg_window), .cfg_threshold(s_threshold),
    .cfg_periodic(cfg_periodic), .clear(clear), .start_evt(s_start), .byte_evt(s_bevt),
    .byte_len(s_len), .rd_sel(s_rd_sel), .rd_bytes(s_rd_bytes), .rd_events(s_rd_events),
    .rd_thresh_cycle(s_rd_tcyc), .rd_thresh_hit(s_rd_thit), .rd_snap_valid(s_rd_valid),
    .ch_state(s_ch_state), .win_done(s_win_done)
  );

  always #5 aclk = ~aclk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    bit          sat;
    logic [63:0] bytes;
    logic [63:0] events;
    logic [63:0] tcyc;
    logic        thit;
    logic        valid;
  } rd_exp_t;

  rd_exp_t sb_q[$];

  // Drive a readout select and queue what must appear one cycle later.
  task automatic expect_rd(input string name, input bit sat, input logic [1:0] sel,
                           input logic [63:0] b, input logic [63:0] e, input logic [63:0] t,
                           input logic h, input logic v);
    rd_exp_t x;
    x.name = name; x.sat = sat; x.bytes = b; x.events = e; x.tcyc = t; x.thit = h; x.valid = v;
    if (sat) s_rd_sel = sel;
    else rd_sel = sel;
    sb_q.push_back(x);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
    while (sb_q.size() > 0) begin
      rd_exp_t x;
      x = sb_q.pop_front();
      if (x.sat) begin
        chk({x.name, ".bytes"},  {56'd0, s_rd_bytes},  x.bytes);
        chk({x.name, ".events"}, {56'd0, s_rd_events}, x.events);
        chk({x.name, ".tcyc"},   {56'd0, s_rd_tcyc},   x.tcyc);
        chk({x.name, ".thit"},   {63'd0, s_rd_thit},   {63'd0, x.thit});
        chk({x.name, ".valid"},  {63'd0, s_rd_valid},  {63'd0, x.valid});
      end else begin
        chk({x.name, ".bytes"},  rd_bytes,        x.bytes);
        chk({x.name, ".events"}, rd_events,       x.events);
        chk({x.name, ".tcyc"},   rd_thresh_cycle, x.tcyc);
        chk({x.name, ".thit"},   {63'd0, rd_thresh_hit}, {63'd0, x.thit});
        chk({x.name, ".valid"},  {63'd0, rd_snap_valid}, {63'd0, x.valid});
      end
    end
  endtask

  typedef struct {
    logic        start;
    logic        bevt;
    logic [15:0] len;
    logic        done;
    logic [1:0]  st;
  } vec_t;

  vec_t vt[12];

  // One-shot window of 10 on ch0; row r is the cycle after the start pulse row 0.
  task automatic run_table(input string tag, input logic [63:0] thr, input bit change_win);
    cfg_threshold = thr;
    cfg_periodic  = 1'b0;
    cfg_window    = 32'd10;
    for (int r = 0; r < 12; r++) begin
      start_evt[0]    = vt[r].start;
      byte_evt[0]     = vt[r].bevt;
      byte_len[15:0]  = vt[r].len;
      if (change_win && r == 2) cfg_window = 32'd3;
      #1;
      chk($sformatf("%s.r%0d.win_done", tag, r), {63'd0, win_done[0]}, {63'd0, vt[r].done});
      chk($sformatf("%s.r%0d.state", tag, r), {62'd0, ch_state[1:0]}, {62'd0, vt[r].st});
      tick();
    end
    start_evt = '0; byte_evt = '0; byte_len = '0;
  endtask

  initial begin
    vt[0]  = '{1'b1, 1'b1, 16'd999, 1'b0, 2'd0};
    vt[1]  = '{1'b0, 1'b1, 16'd100, 1'b0, 2'd1};
    vt[2]  = '{1'b0, 1'b0, 16'd0,   1'b0, 2'd1};
    vt[3]  = '{1'b1, 1'b0, 16'd0,   1'b0, 2'd1};
    vt[4]  = '{1'b0, 1'b0, 16'd0,   1'b0, 2'd1};
    vt[5]  = '{1'b0, 1'b1, 16'd100, 1'b0, 2'd1};
    vt[6]  = '{1'b0, 1'b0, 16'd0,   1'b0, 2'd1};
    vt[7]  = '{1'b0, 1'b0, 16'd0,   1'b0, 2'd1};
    vt[8]  = '{1'b0, 1'b0, 16'd0,   1'b0, 2'd1};
    vt[9]  = '{1'b0, 1'b0, 16'd0,   1'b0, 2'd1};
    vt[10] = '{1'b0, 1'b1, 16'd100, 1'b1, 2'd1};
    vt[11] = '{1'b0, 1'b0, 16'd0,   1'b0, 2'd2};

    areset = 1'b1; cfg_window = '0; cfg_threshold = '0; cfg_periodic = 1'b0; clear = 1'b0;
    start_evt = '0; byte_evt = '0; byte_len = '0; rd_sel = '0;
    s_threshold = '0; s_start = '0; s_bevt = '0; s_len = '0; s_rd_sel = '0;
    tick(); tick();
    chk("reset.rd_bytes", rd_bytes, 64'd0);
    chk("reset.rd_events", rd_events, 64'd0);
    chk("reset.rd_tcyc", rd_thresh_cycle, 64'd0);
    chk("reset.rd_thit", {63'd0, rd_thresh_hit}, 64'd0);
    chk("reset.rd_valid", {63'd0, rd_snap_valid}, 64'd0);
    chk("reset.ch_state", {56'd0, ch_state}, 64'd0);
    chk("reset.win_done", {60'd0, win_done}, 64'd0);
    areset = 1'b0;
    tick();

    // Start with a zero window must be ignored.
    start_evt[0] = 1'b1;
    tick();
    start_evt = '0;
    chk("zero_win.state", {56'd0, ch_state}, 64'd0);

    run_table("oneshot", 64'd0, 1'b0);
    expect_rd("oneshot.rd", 1'b0, 2'd0, 64'd300, 64'd3, 64'd0, 1'b0, 1'b1);
    tick();

    // Re-arm from HOLD with a threshold; mid-window cfg_window change must not matter.
    vt[0].st = 2'd2;
    run_table("thresh", 64'd150, 1'b1);
    expect_rd("thresh.rd", 1'b0, 2'd0, 64'd300, 64'd3, 64'd4, 1'b1, 1'b1);
    tick();

    // Periodic ch1, window 8, one 64-byte event per window.
    cfg_threshold = '0; cfg_periodic = 1'b1; cfg_window = 32'd8;
    start_evt[1] = 1'b1;
    tick();
    start_evt = '0;
    for (int c = 1; c <= 24; c++) begin
      int wc;
      wc = (c - 1) % 8;
      byte_evt[1] = (wc == 2);
      byte_len[31:16] = 16'd64;
      if (c > 1 && wc == 0)
        expect_rd($sformatf("periodic.c%0d", c), 1'b0, 2'd1, 64'd64, 64'd1, 64'd0, 1'b0, 1'b1);
      #1;
      chk($sformatf("periodic.c%0d.win_done", c), {63'd0, win_done[1]}, {63'd0, wc == 7});
      chk($sformatf("periodic.c%0d.state", c), {62'd0, ch_state[3:2]}, 64'd1);
      tick();
    end
    byte_evt = '0;
    expect_rd("periodic.c25", 1'b0, 2'd1, 64'd64, 64'd1, 64'd0, 1'b0, 1'b1);
    cfg_periodic = 1'b0;
    tick();

    // clear coinciding with start_evt, byte_evt and the last window cycle on ch2.
    cfg_window = 32'd4;
    start_evt[2] = 1'b1;
    tick();
    start_evt = '0;
    for (int c = 1; c <= 3; c++) begin
      byte_evt[2] = (c == 1);
      byte_len[47:32] = 16'd5;
      #1;
      chk($sformatf("clr.c%0d.state", c), {62'd0, ch_state[5:4]}, 64'd1);
      tick();
    end
    clear = 1'b1; start_evt = 4'b0101; byte_evt = 4'b0100;
    #1;
    chk("clr.win_done", {60'd0, win_done}, 64'd0);
    tick();
    clear = 1'b0; start_evt = '0; byte_evt = '0; byte_len = '0;
    chk("clr.ch_state", {56'd0, ch_state}, 64'd0);
    expect_rd("clr.rd2", 1'b0, 2'd2, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0);
    tick();
    expect_rd("clr.rd0", 1'b0, 2'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0);
    tick();

    // All channels at once, window 3; readout on the snapshot cycle returns the old value.
    cfg_window = 32'd3;
    start_evt = 4'hF;
    tick();
    start_evt = '0;
    tick();
    byte_evt = 4'hF;
    for (int i = 0; i < 4; i++) byte_len[i*16 +: 16] = 16'(10 * (i + 1));
    tick();
    byte_evt = '0;
    expect_rd("all.same_cycle", 1'b0, 2'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0);
    #1;
    chk("all.win_done", {60'd0, win_done}, 64'hF);
    tick();
    chk("all.ch_state", {56'd0, ch_state}, 64'hAA);
    for (int i = 0; i < 4; i++) begin
      expect_rd($sformatf("all.rd%0d", i), 1'b0, 2'(i), 64'(10 * (i + 1)), 64'd1, 64'd0,
                1'b0, 1'b1);
      tick();
    end

    // Saturation on the 8-bit instance: 200 + 200 clamps to 255.
    cfg_window = 32'd4;
    s_start[0] = 1'b1;
    tick();
    s_start = '0;
    for (int c = 1; c <= 4; c++) begin
      s_bevt[0] = (c <= 2);
      s_len[15:0] = 16'd200;
      #1;
      chk($sformatf("sat.c%0d.win_done", c), {63'd0, s_win_done[0]}, {63'd0, c == 4});
      tick();
    end
    s_bevt = '0;
    expect_rd("sat.rd0", 1'b1, 2'd0, 64'd255, 64'd2, 64'd0, 1'b0, 1'b1);
    tick();
    expect_rd("sat.rd_oor", 1'b1, 2'd3, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/network_perf_monitor.md
Name: network_perf_monitor

Overview:
- Multi-channel, windowed throughput and latency monitor for the network kernel.
- Replaces the ad-hoc tx/rx cycle and byte counters currently inlined next to network_stack.
- Each channel is armed by a start event, accumulates bytes and events over a runtime-programmable cycle window, and latches a snapshot at window end.
- Snapshots are read through an indexed, registered readout port for ILA or host register access.

Parameters:
- NUM_CH, 4, number of independent measurement channels (1..16).
- CNT_W, 64, width of byte/event/cycle counters and snapshots.
- LEN_W, 16, width of each per-event byte length field.
- SEL_W, 2, readout select width; must equal max(1, clog2(NUM_CH)).

Ports:
- aclk  in  1  kernel clock; all logic is on this clock.
- areset  in  1  asynchronous, active-high reset.
- cfg_window  in  32  window length in cycles; sampled per channel on arm.
- cfg_threshold  in  CNT_W  byte threshold for time-to-threshold capture; 0 = disabled.
- cfg_periodic  in  1  1 = auto re-arm at window end; 0 = one-shot.
- clear  in  1  synchronous clear of all channels.
- start_evt  in  NUM_CH  per-channel start pulse (valid&ready of the start stream).
- byte_evt  in  NUM_CH  per-channel byte-accounting pulse.
- byte_len  in  NUM_CH*LEN_W  byte count for channel i in bits [i*LEN_W +: LEN_W].
- rd_sel  in  SEL_W  channel selected for readout.
- rd_bytes  out  CNT_W  snapshot byte total.
- rd_events  out  CNT_W  snapshot byte_evt count.
- rd_thresh_cycle  out  CNT_W  window cycle index at which the threshold was reached.
- rd_thresh_hit  out  1  threshold was reached in the snapshot window.
- rd_snap_valid  out  1  at least one snapshot has been taken since reset/clear.
- ch_state  out  2*NUM_CH  per-channel state encoding: 0 IDLE, 1 RUN, 2 HOLD.
- win_done  out  NUM_CH  1-cycle pulse on the last cycle of a window.

Behaviour:
- Reset (areset high):
  - All channels go to IDLE.
  - All counters, snapshots and rd_* outputs are 0.
  - win_done = 0; ch_state = 0.
- Per-channel state machine:
  - IDLE -> RUN on start_evt[i] when cfg_window != 0. The window length is latched, and the cycle, byte and event counters and threshold flag are zeroed. start_evt with cfg_window == 0 is ignored.
  - RUN: the cycle counter cyc increments every cycle. Window cycle 0 is the cycle after the start pulse.
  - RUN, cyc == window-1 (last cycle):
    - Snapshot is taken, including any byte_evt on that cycle.
    - win_done[i] pulses and snap_valid is set.
    - If cfg_periodic = 1, the channel stays in RUN with counters zeroed, so the next window starts with no gap cycle.
    - If cfg_periodic = 0, the channel goes to HOLD.
  - HOLD -> RUN on start_evt[i], same arm rules as from IDLE. The snapshot is retained until overwritten.
  - start_evt in RUN is ignored (no restart).
- Accounting, RUN only:
  - On byte_evt[i], bytes += byte_len and events += 1.
  - Both saturate at 2^CNT_W-1; they never wrap.
  - byte_evt on the arm cycle, or in IDLE/HOLD, is ignored.
- Threshold:
  - Applies when cfg_threshold != 0 and the threshold flag is still clear.
  - On the first cycle where the post-add byte total >= cfg_threshold: thresh_cycle = cyc of that cycle, flag set.
  - Later crossings in the same window are ignored.
  - The flag and thresh_cycle are included in the snapshot and cleared with the counters.
- clear:
  - All channels go to IDLE; snapshots, snap_valid and counters are zeroed.
  - clear wins over simultaneous start_evt, byte_evt or window end.
  - win_done stays 0 on that cycle.
- Readout:
  - rd_* are registered with 1-cycle latency: the values reflect rd_sel and snapshot contents of the previous cycle.
  - rd_sel >= NUM_CH returns all zeros.
- A snapshot update and a readout of the same channel on the same cycle return the old snapshot; the new one appears the following cycle.
- Channels are fully independent; simultaneous events on all channels are all processed.
- cfg_* changes mid-window have no effect on cfg_window (latched at arm). cfg_threshold and cfg_periodic are used live.

Test Plan:
- Reset, rd_sel=0 -> all rd_* 0, ch_state 0, win_done 0.
- One-shot ch0, window=10, byte_evt len=100 on window cycles 0,4,9 -> win_done[0] on cycle 9; HOLD; rd_bytes=300, rd_events=3.
- ch0 threshold=150, same stimulus -> rd_thresh_hit=1, rd_thresh_cycle=4.
- Periodic ch1, window=8, one len=64 event per window -> back-to-back win_done every 8 cycles; each snapshot rd_bytes=64; state stays RUN.
- clear asserted with start_evt and the last window cycle on ch2 -> IDLE, rd_snap_valid=0, no win_done.
- Saturation with CNT_W=8, byte_len=200 twice -> rd_bytes=255; rd_sel=NUM_CH -> zeros.
